// File: rtl/elevator_car_controller_pkg.sv
// Shared codes, sizes and bit-index helpers for the elevator car controller.
package elevator_pkg;

   localparam logic [1:0] STOP   = 2'b00;
   localparam logic [1:0] UP     = 2'b10;
   localparam logic [1:0] DOWN   = 2'b01;
   localparam logic [1:0] UPDOWN = 2'b11;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam int FLOOR_MIN   = 1;
   localparam int FLOOR_MAX   = 7;
   localparam int NUM_BUTTONS = 14;

   // Hall-call bit positions for floor f (1-based)
   function automatic int upBit(input int f);
      return 2 * f - 1;
   endfunction

   function automatic int downBit(input int f);
      return 2 * f - 2;
   endfunction

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } carState_t;

endpackage

// File: rtl/elevator_car_controller_if.sv
// Dispatcher <-> car bundle. master = dispatcher side, slave = car controller.
interface elevator_car_controller_if;
   import elevator_pkg::*;

   logic [NUM_BUTTONS-1:0] assignedFloorButton;
   logic [FLOOR_MAX-1:0]   carButton;
   logic [2:0]             currentFloor;
   logic [1:0]             direction;
   logic                   doorOpen;
   logic [NUM_BUTTONS-1:0] currentFloorButton;
   logic [NUM_BUTTONS-1:0] servicedButton;

   modport master (
      output assignedFloorButton, carButton,
      input  currentFloor, direction, doorOpen, currentFloorButton, servicedButton
   );

   modport slave (
      input  assignedFloorButton, carButton,
      output currentFloor, direction, doorOpen, currentFloorButton, servicedButton
   );

endinterface

// File: rtl/elevator_car_controller_request_scan.sv
// Combinational view of the pending calls relative to the car: where calls
// are, which way is nearer, whether the next floor is a stop, and which bits
// qualify for service at the current and next floor.
module elevator_request_scan
   import elevator_pkg::*;
(
   input  logic [NUM_BUTTONS-1:0] pendHall,
   input  logic [FLOOR_MAX-1:0]   pendCar,
   input  logic [2:0]             floor,
   input  logic [1:0]             dir,
   output logic                   here,
   output logic                   above,
   output logic                   below,
   output logic                   preferUp,
   output logic                   stopNext,
   output logic [NUM_BUTTONS-1:0] qualHereHall,
   output logic [FLOOR_MAX-1:0]   qualHereCar,
   output logic [NUM_BUTTONS-1:0] qualNextHall,
   output logic [FLOOR_MAX-1:0]   qualNextCar
);

   // Everything below works in floor space: bit g is floor g+1
   logic [FLOOR_MAX-1:0] hallUp, hallDn, reqAt;
   logic [FLOOR_MAX-1:0] curHot, belowMask, aboveMask;
   logic [FLOOR_MAX-1:0] nextHot, aheadNextMask;
   logic [FLOOR_MAX-1:0] hereUpHot, hereDnHot, nextUpHot, nextDnHot;
   logic [FLOOR_MAX-2:0] upAt, downAt, anyAt, nearest;
   logic                 dirUp, aheadHere, aheadNext, atEnd;

   for (genvar g = 0; g < FLOOR_MAX; g++) begin : g_floor
      assign hallUp[g]          = pendHall[2*g+1];
      assign hallDn[g]          = pendHall[2*g];
      assign reqAt[g]           = pendCar[g] | hallUp[g] | hallDn[g];
      assign qualHereHall[2*g+1] = hereUpHot[g];
      assign qualHereHall[2*g]   = hereDnHot[g];
      assign qualNextHall[2*g+1] = nextUpHot[g];
      assign qualNextHall[2*g]   = nextDnHot[g];
   end

   // bit k-1 flags a call exactly k floors up / down
   for (genvar k = 0; k < FLOOR_MAX - 1; k++) begin : g_dist
      assign upAt[k]   = |(reqAt & (curHot << (k + 1)));
      assign downAt[k] = |(reqAt & (curHot >> (k + 1)));
   end

   // Position masks, nearest-call choice and the committed-direction lookahead
   always_comb begin
      curHot    = 7'b1 << (floor - 3'd1);
      belowMask = curHot - 7'd1;
      aboveMask = ~(belowMask | curHot);
      here      = |(reqAt & curHot);
      above     = |(reqAt & aboveMask);
      below     = |(reqAt & belowMask);

      // lowest set distance wins; a tie leaves the UP bit set there
      anyAt    = upAt | downAt;
      nearest  = anyAt & (~anyAt + 6'd1);
      preferUp = |(upAt & nearest);

      unique case (dir)
         UP:           aheadHere = above;
         DOWN:         aheadHere = below;
         STOP, UPDOWN: aheadHere = 1'b0;
      endcase
   end

   // Service qualification here, and the stop test one floor ahead
   always_comb begin
      dirUp = (dir == UP);

      hereUpHot   = curHot & {FLOOR_MAX{(dir != DOWN) | ~aheadHere}};
      hereDnHot   = curHot & {FLOOR_MAX{(dir != UP) | ~aheadHere}};
      qualHereCar = curHot;

      nextHot       = dirUp ? (curHot << 1) : (curHot >> 1);
      aheadNextMask = dirUp ? ~((nextHot - 7'd1) | nextHot) : (nextHot - 7'd1);
      aheadNext     = |(reqAt & aheadNextMask);
      atEnd         = dirUp ? nextHot[FLOOR_MAX-1] : nextHot[0];

      nextUpHot   = nextHot & {FLOOR_MAX{dirUp | ~aheadNext}};
      nextDnHot   = nextHot & {FLOOR_MAX{~dirUp | ~aheadNext}};
      qualNextCar = nextHot;

      stopNext = |(pendCar & nextHot) | |(hallUp & nextUpHot) |
                 |(hallDn & nextDnHot) | atEnd;
   end

endmodule

// File: rtl/elevator_car_controller.sv
// Per-car motion and door controller: latches hall/car calls, steps the car
// floor by floor, holds the door open at served floors, reports service.
//
//   state     | meaning
//   IDLE      | no heading, waiting for a pending call
//   MOVE_UP   | travelling up, floor steps at each travel-counter wrap
//   MOVE_DOWN | travelling down, floor steps at each travel-counter wrap
//   DOOR_OPEN | door open, heading kept, absorbs qualifying calls here
module elevator_car_controller
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6
) (
   input logic                      clk,
   input logic                      reset,
   elevator_car_controller_if.slave bus
);

   localparam int TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DW = $clog2(DOOR_CYCLES + 1);
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES);
   localparam logic [DW-1:0] DOOR_LAST   = DW'(1);
   // floor 7 has no UP call and floor 1 no DOWN call
   localparam logic [NUM_BUTTONS-1:0] HALL_ENTRY_MASK =
      ~((NUM_BUTTONS'(1) << upBit(FLOOR_MAX)) | (NUM_BUTTONS'(1) << downBit(FLOOR_MIN)));

   carState_t              state, stateNext;
   logic [2:0]             floorReg, floorNext;
   logic [1:0]             dirReg, dirNext;
   logic [TW-1:0]          travelCnt, travelNext;
   logic [DW-1:0]          doorCnt, doorNext;
   logic [NUM_BUTTONS-1:0] pendHall, hallNext, servReg, inHall, clrHall;
   logic [FLOOR_MAX-1:0]   pendCar, carNext, inCar, clrCar;
   logic                   doorOpenReg;

   logic                   here, above, below, preferUp, stopNext;
   logic [NUM_BUTTONS-1:0] qualHereHall, qualNextHall;
   logic [FLOOR_MAX-1:0]   qualHereCar, qualNextCar;

   elevator_request_scan uScan (
      .pendHall     (pendHall),
      .pendCar      (pendCar),
      .floor        (floorReg),
      .dir          (dirReg),
      .here         (here),
      .above        (above),
      .below        (below),
      .preferUp     (preferUp),
      .stopNext     (stopNext),
      .qualHereHall (qualHereHall),
      .qualHereCar  (qualHereCar),
      .qualNextHall (qualNextHall),
      .qualNextCar  (qualNextCar)
   );

   assign bus.currentFloor       = floorReg;
   assign bus.direction          = dirReg;
   assign bus.doorOpen           = doorOpenReg;
   assign bus.currentFloorButton = pendHall;
   assign bus.servicedButton     = servReg;

   // Next state, heading, counters and request latches
   always_comb begin
      inHall     = bus.assignedFloorButton & HALL_ENTRY_MASK;
      inCar      = bus.carButton;
      stateNext  = state;
      dirNext    = dirReg;
      floorNext  = floorReg;
      travelNext = travelCnt;
      doorNext   = doorCnt;
      clrHall    = '0;
      clrCar     = '0;

      unique case (state)
         IDLE: begin
            dirNext    = STOP;
            travelNext = '0;
            if (here) begin
               stateNext = DOOR_OPEN;
               clrHall   = pendHall & qualHereHall;
               clrCar    = pendCar & qualHereCar;
               doorNext  = DOOR_LOAD;
            end else if (above && (!below || preferUp)) begin
               stateNext = MOVE_UP;
               dirNext   = UP;
            end else if (below) begin
               stateNext = MOVE_DOWN;
               dirNext   = DOWN;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (travelCnt == TRAVEL_LAST) begin
               travelNext = '0;
               floorNext  = (state == MOVE_UP) ? floorReg + 3'd1 : floorReg - 3'd1;
               if (stopNext) begin
                  stateNext = DOOR_OPEN;
                  clrHall   = pendHall & qualNextHall;
                  clrCar    = pendCar & qualNextCar;
                  doorNext  = DOOR_LOAD;
               end
            end else begin
               travelNext = travelCnt + TW'(1);
            end
         end
         DOOR_OPEN: begin
            // pending bits are included so a call re-set on the entry edge is still served
            clrHall = (pendHall | inHall) & qualHereHall;
            clrCar  = (pendCar | inCar) & qualHereCar;
            if ((|clrHall) || (|clrCar)) begin
               doorNext = DOOR_LOAD;
            end else if (doorCnt == DOOR_LAST) begin
               doorNext   = '0;
               travelNext = '0;
               if (dirReg == UP && above) begin
                  stateNext = MOVE_UP;
               end else if (dirReg == DOWN && below) begin
                  stateNext = MOVE_DOWN;
               end else if (dirReg == UP && below) begin
                  stateNext = MOVE_DOWN;
                  dirNext   = DOWN;
               end else if (dirReg == DOWN && above) begin
                  stateNext = MOVE_UP;
                  dirNext   = UP;
               end else begin
                  stateNext = IDLE;
                  dirNext   = STOP;
               end
            end else begin
               doorNext = doorCnt - DW'(1);
            end
         end
      endcase

      // a new call normally beats a clear; at an open door it is absorbed instead
      if (state == DOOR_OPEN) begin
         hallNext = (pendHall | inHall) & ~clrHall;
         carNext  = (pendCar | inCar) & ~clrCar;
      end else begin
         hallNext = (pendHall & ~clrHall) | inHall;
         carNext  = (pendCar & ~clrCar) | inCar;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Position, counters, latches and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         floorReg    <= 3'(FLOOR_MIN);
         dirReg      <= STOP;
         travelCnt   <= '0;
         doorCnt     <= '0;
         pendHall    <= '0;
         pendCar     <= '0;
         servReg     <= '0;
         doorOpenReg <= OFF;
      end else begin
         floorReg    <= floorNext;
         dirReg      <= dirNext;
         travelCnt   <= travelNext;
         doorCnt     <= doorNext;
         pendHall    <= hallNext;
         pendCar     <= carNext;
         servReg     <= clrHall;
         doorOpenReg <= (stateNext == DOOR_OPEN) ? ON : OFF;
      end
   end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller (TRAVEL_CYCLES=4, DOOR_CYCLES=6).
module tb_elevator_car_controller;

   logic clk = 1'b0;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;

   elevator_car_controller_if bus ();

   elevator_car_controller #(
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      reset                   = 1'b0;
      bus.assignedFloorButton = '0;
      bus.carButton           = '0;
      #12;
      check("rst_floor", 32'(bus.currentFloor), 1);
      check("rst_dir", 32'(bus.direction), 0);
      check("rst_door", 32'(bus.doorOpen), 0);
      check("rst_cfb", 32'(bus.currentFloorButton), 0);
      check("rst_serv", 32'(bus.servicedButton), 0);
      reset = 1'b1;
      tick();

      // masked hall bits (floor 7 UP, floor 1 DOWN)
      bus.assignedFloorButton = 14'h2001;
      tick();
      bus.assignedFloorButton = '0;
      check("mask_cfb", 32'(bus.currentFloorButton), 0);
      tick(3);
      check("mask_dir", 32'(bus.direction), 0);
      check("mask_door", 32'(bus.doorOpen), 0);
      check("mask_floor", 32'(bus.currentFloor), 1);

      // floor-3 UP call from floor 1
      bus.assignedFloorButton = 14'h0020;
      tick();                                    // E0
      bus.assignedFloorButton = '0;
      check("t1_cfb_e0", 32'(bus.currentFloorButton), 32'h20);
      check("t1_dir_e0", 32'(bus.direction), 0);
      tick();                                    // E1
      check("t1_dir_e1", 32'(bus.direction), 2);
      check("t1_floor_e1", 32'(bus.currentFloor), 1);
      tick(4);                                   // E5
      check("t1_floor_e5", 32'(bus.currentFloor), 2);
      check("t1_door_e5", 32'(bus.doorOpen), 0);
      tick(3);                                   // E8
      check("t1_floor_e8", 32'(bus.currentFloor), 2);
      tick();                                    // E9
      check("t1_floor_e9", 32'(bus.currentFloor), 3);
      check("t1_door_e9", 32'(bus.doorOpen), 1);
      check("t1_serv_e9", 32'(bus.servicedButton), 32'h20);
      check("t1_cfb_e9", 32'(bus.currentFloorButton), 0);
      check("t1_dir_e9", 32'(bus.direction), 2);
      tick();                                    // E10
      check("t1_serv_e10", 32'(bus.servicedButton), 0);
      tick(4);                                   // E14
      check("t1_door_e14", 32'(bus.doorOpen), 1);
      check("t1_dir_e14", 32'(bus.direction), 2);
      tick();                                    // E15
      check("t1_door_e15", 32'(bus.doorOpen), 0);
      check("t1_dir_e15", 32'(bus.direction), 0);

      // door at floor 3 from IDLE, then reload by car button 3 and hall bit 4
      bus.carButton = 7'b0000100;
      tick();                                    // F0
      bus.carButton = '0;
      check("t4_door_f0", 32'(bus.doorOpen), 0);
      tick();                                    // F1
      check("t4_door_f1", 32'(bus.doorOpen), 1);
      check("t4_dir_f1", 32'(bus.direction), 0);
      check("t4_serv_f1", 32'(bus.servicedButton), 0);
      tick(3);                                   // F4
      bus.carButton = 7'b0000100;
      tick();                                    // F5 reload
      bus.carButton = '0;
      check("t4_door_f5", 32'(bus.doorOpen), 1);
      tick(2);                                   // F7
      check("t4_reload_f7", 32'(bus.doorOpen), 1);
      tick();                                    // F8
      bus.assignedFloorButton = 14'h0010;
      tick();                                    // F9 reload
      bus.assignedFloorButton = '0;
      check("t4_serv_f9", 32'(bus.servicedButton), 32'h10);
      check("t4_cfb_f9", 32'(bus.currentFloorButton), 0);
      tick();                                    // F10
      check("t4_serv_f10", 32'(bus.servicedButton), 0);
      tick(4);                                   // F14
      check("t4_door_f14", 32'(bus.doorOpen), 1);
      tick();                                    // F15
      check("t4_door_f15", 32'(bus.doorOpen), 0);
      check("t4_floor_f15", 32'(bus.currentFloor), 3);

      // reset while travelling between floors 3 and 4
      bus.carButton           = 7'b0010000;
      bus.assignedFloorButton = 14'h0800;
      tick();                                    // G0
      bus.carButton           = '0;
      bus.assignedFloorButton = '0;
      check("t5_cfb_g0", 32'(bus.currentFloorButton), 32'h800);
      tick();                                    // G1
      check("t5_dir_g1", 32'(bus.direction), 2);
      tick(2);                                   // G3
      check("t5_floor_g3", 32'(bus.currentFloor), 3);
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_floor", 32'(bus.currentFloor), 1);
      check("t5_rst_dir", 32'(bus.direction), 0);
      check("t5_rst_door", 32'(bus.doorOpen), 0);
      check("t5_rst_cfb", 32'(bus.currentFloorButton), 0);
      check("t5_rst_serv", 32'(bus.servicedButton), 0);
      reset = 1'b1;
      tick(3);
      check("t5_post_floor", 32'(bus.currentFloor), 1);
      check("t5_post_dir", 32'(bus.direction), 0);
      check("t5_post_cfb", 32'(bus.currentFloorButton), 0);

      // car calls to floors 4 and 2 from floor 1
      bus.carButton = 7'b0001010;
      tick();                                    // H0
      bus.carButton = '0;
      tick();                                    // H1
      check("t2_dir_h1", 32'(bus.direction), 2);
      tick(4);                                   // H5
      check("t2_floor_h5", 32'(bus.currentFloor), 2);
      check("t2_door_h5", 32'(bus.doorOpen), 1);
      check("t2_dir_h5", 32'(bus.direction), 2);
      check("t2_serv_h5", 32'(bus.servicedButton), 0);
      tick(5);                                   // H10
      check("t2_door_h10", 32'(bus.doorOpen), 1);
      check("t2_dir_h10", 32'(bus.direction), 2);
      tick();                                    // H11
      check("t2_door_h11", 32'(bus.doorOpen), 0);
      check("t2_dir_h11", 32'(bus.direction), 2);
      check("t2_floor_h11", 32'(bus.currentFloor), 2);
      tick(4);                                   // H15
      check("t2_floor_h15", 32'(bus.currentFloor), 3);
      check("t2_door_h15", 32'(bus.doorOpen), 0);
      tick(4);                                   // H19
      check("t2_floor_h19", 32'(bus.currentFloor), 4);
      check("t2_door_h19", 32'(bus.doorOpen), 1);
      tick(6);                                   // H25
      check("t2_door_h25", 32'(bus.doorOpen), 0);
      check("t2_dir_h25", 32'(bus.direction), 0);

      // tie at floor 4: floor-6 DOWN and floor-2 UP, UP wins
      bus.assignedFloorButton = 14'h0408;
      tick();                                    // J0
      bus.assignedFloorButton = '0;
      check("t3_cfb_j0", 32'(bus.currentFloorButton), 32'h408);
      tick();                                    // J1
      check("t3_dir_j1", 32'(bus.direction), 2);
      tick(4);                                   // J5
      check("t3_floor_j5", 32'(bus.currentFloor), 5);
      tick(4);                                   // J9
      check("t3_floor_j9", 32'(bus.currentFloor), 6);
      check("t3_door_j9", 32'(bus.doorOpen), 1);
      check("t3_serv_j9", 32'(bus.servicedButton), 32'h400);
      check("t3_cfb_j9", 32'(bus.currentFloorButton), 32'h008);
      tick(6);                                   // J15
      check("t3_door_j15", 32'(bus.doorOpen), 0);
      check("t3_dir_j15", 32'(bus.direction), 1);
      tick(16);                                  // J31
      check("t3_floor_j31", 32'(bus.currentFloor), 2);
      check("t3_door_j31", 32'(bus.doorOpen), 1);
      check("t3_serv_j31", 32'(bus.servicedButton), 32'h008);
      check("t3_cfb_j31", 32'(bus.currentFloorButton), 0);
      tick(6);                                   // J37
      check("t3_dir_j37", 32'(bus.direction), 0);
      check("t3_door_j37", 32'(bus.doorOpen), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
